// File: rtl/riscv_pkg.sv
// Shared core types: machine word, byte strobes and the memory request bundle
// carried from a requester to the slave port.
package riscv;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  // addr is a full word; narrower address buses are zero-extended into it.
  typedef struct packed {
    logic  we;
    word_t addr;
    word_t wdata;
    strb_t strb;
  } mem_req_t;
endpackage

// File: rtl/id_fifo.sv
// In-order owner FIFO: one entry per accepted-but-unanswered slave transaction,
// holding the index of the requester that issued it.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign full   = (r_count == (PW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_arbiter.sv
// N-to-1 arbiter onto a pipelined memory slave with in-order response routing.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module mem_arbiter
  import riscv::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        m_req,
  input  logic [N-1:0]        m_we,
  input  logic [N*ADDR_W-1:0] m_addr,
  input  logic [N*32-1:0]     m_wdata,
  input  logic [N*4-1:0]      m_strb,
  output logic [N-1:0]        m_gnt,
  output logic [N-1:0]        m_rvalid,
  output logic [31:0]         m_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [31:0]         s_wdata,
  output logic [3:0]          s_strb,
  input  logic                s_gnt,
  input  logic                s_rvalid,
  input  logic [31:0]         s_rdata
);
  localparam int IDX_W = $clog2(N);

  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_head;
  logic             w_full, w_empty, w_accept;
  mem_req_t         w_sel;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_next_ptr;
`endif

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    w_winner = '0;
    for (int i = N-1; i >= 0; i--)
      if (m_req[i]) w_winner = IDX_W'(i);
`else
    begin : rr_search
      int   j;
      logic found;
      w_winner = '0;
      found    = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (int'(r_rr_ptr) + k) % N;
        if (!found && m_req[j]) begin
          found    = 1'b1;
          w_winner = IDX_W'(j);
        end
      end
    end
`endif
    // A stalled request keeps the port until the slave takes it.
    if (r_locked) w_winner = r_lock_idx;
  end

  always_comb begin
    w_sel.we    = m_we[w_winner];
    w_sel.addr  = word_t'(m_addr[w_winner*ADDR_W +: ADDR_W]);
    w_sel.wdata = m_wdata[w_winner*32 +: 32];
    w_sel.strb  = m_strb[w_winner*4 +: 4];
  end

  assign s_req    = (|m_req) & ~w_full;
  assign s_we     = w_sel.we;
  assign s_addr   = ADDR_W'(w_sel.addr);
  assign s_wdata  = w_sel.wdata;
  assign s_strb   = w_sel.strb;
  assign w_accept = s_req & s_gnt;
  assign m_rdata  = s_rdata;

  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    if (w_accept)             m_gnt[w_winner]  = 1'b1;
    if (s_rvalid && !w_empty) m_rvalid[w_head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (s_req && !s_gnt) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_winner;
    end else if (w_accept) begin
      r_locked   <= 1'b0;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  assign w_next_ptr = (w_winner == IDX_W'(N-1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)         r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= w_next_ptr;
  end
`endif

  id_fifo #(.DEPTH(DEPTH), .WIDTH(IDX_W)) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .din   (w_winner),
    .pop   (s_rvalid),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter (N=2, DEPTH=4); expectations follow
// MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_arbiter;
  localparam int N = 2, AW = 32, DEPTH = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  // second grant of an alternating pair: round-robin gives r1, fixed gives r0
  localparam logic [1:0] ALT  = FP ? 2'b01 : 2'b10;
  localparam logic       ALTW = FP ? 1'b0 : 1'b1;

  logic          clk = 1'b0, reset;
  logic [N-1:0]  m_req, m_we, m_gnt, m_rvalid;
  logic [N*AW-1:0] m_addr;
  logic [N*32-1:0] m_wdata;
  logic [N*4-1:0]  m_strb;
  logic [31:0]   m_rdata, s_wdata, s_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_strb;

  logic [31:0] addr_c  [2] = '{32'h0000_0200, 32'h0000_0100};
  logic [31:0] wdata_c [2] = '{32'h1111_1111, 32'h2222_2222};
  logic [3:0]  strb_c  [2] = '{4'hF, 4'h3};

  assign m_addr  = {addr_c[1], addr_c[0]};
  assign m_wdata = {wdata_c[1], wdata_c[0]};
  assign m_strb  = {strb_c[1], strb_c[0]};

  mem_arbiter #(.N(N), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_strb(m_strb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_strb(s_strb),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req, we;
    logic        sgnt, srv;
    logic [31:0] rdata;
    logic [1:0]  egnt, erv;
    logic        esreq, ewin, eswe;
  } vec_t;

  function automatic vec_t v(logic [1:0] req, logic [1:0] we, logic sgnt, logic srv,
                             logic [31:0] rdata, logic [1:0] egnt, logic [1:0] erv,
                             logic esreq, logic ewin, logic eswe);
    vec_t t;
    t.req = req; t.we = we; t.sgnt = sgnt; t.srv = srv; t.rdata = rdata;
    t.egnt = egnt; t.erv = erv; t.esreq = esreq; t.ewin = ewin; t.eswe = eswe;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    m_req = t.req; m_we = t.we; s_gnt = t.sgnt; s_rvalid = t.srv; s_rdata = t.rdata;
    #1;
    chk($sformatf("v%0d m_gnt", idx), 32'(m_gnt), 32'(t.egnt));
    chk($sformatf("v%0d m_rvalid", idx), 32'(m_rvalid), 32'(t.erv));
    chk($sformatf("v%0d s_req", idx), 32'(s_req), 32'(t.esreq));
    if (t.erv != 2'b00) chk($sformatf("v%0d m_rdata", idx), m_rdata, t.rdata);
    if (t.esreq) begin
      chk($sformatf("v%0d s_addr", idx), s_addr, addr_c[t.ewin]);
      chk($sformatf("v%0d s_wdata", idx), s_wdata, wdata_c[t.ewin]);
      chk($sformatf("v%0d s_strb", idx), 32'(s_strb), 32'(strb_c[t.ewin]));
      chk($sformatf("v%0d s_we", idx), 32'(s_we), 32'(t.eswe));
    end
  endtask

  vec_t vt[$];

  initial begin
    // req we sgnt srv rdata | gnt rvalid sreq win we
    vt.push_back(v(2'b00, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0, 0)); // idle
    vt.push_back(v(2'b10, 2'b00, 1, 0, 32'h0,         2'b10, 2'b00, 1, 1, 0)); // single r1 read
    vt.push_back(v(2'b00, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'hDEADBEEF,  2'b00, 2'b10, 0, 0, 0)); // routed to r1
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'hCAFEF00D,  2'b00, 2'b00, 0, 0, 0)); // empty: dropped
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0)); // alternation
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         ALT,   2'b00, 1, ALTW, 0));
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0));
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         ALT,   2'b00, 1, ALTW, 0)); // 4th: full
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b00, 2'b00, 0, 0, 0)); // full blocks
    vt.push_back(v(2'b11, 2'b00, 1, 1, 32'h0000_000A, 2'b00, 2'b01, 0, 0, 0)); // pop, still blocked
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0)); // reasserts
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_000B, 2'b00, ALT,   0, 0, 0)); // drain
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_000C, 2'b00, 2'b01, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_000D, 2'b00, ALT,   0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_000E, 2'b00, 2'b01, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_000F, 2'b00, 2'b00, 0, 0, 0));
    vt.push_back(v(2'b10, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 1, 1, 0)); // stall lock
    vt.push_back(v(2'b11, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 1, 1, 0));
    vt.push_back(v(2'b11, 2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 1, 1, 0));
    vt.push_back(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b10, 2'b00, 1, 1, 0));
    vt.push_back(v(2'b01, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_0011, 2'b00, 2'b10, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_0012, 2'b00, 2'b01, 0, 0, 0));
    vt.push_back(v(2'b01, 2'b01, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 1)); // r0 write
    vt.push_back(v(2'b10, 2'b00, 1, 0, 32'h0,         2'b10, 2'b00, 1, 1, 0)); // r1 read
    vt.push_back(v(2'b01, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0)); // r0 read
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_0021, 2'b00, 2'b01, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_0022, 2'b00, 2'b10, 0, 0, 0));
    vt.push_back(v(2'b00, 2'b00, 0, 1, 32'h0000_0023, 2'b00, 2'b01, 0, 0, 0));

    reset = 1'b1; m_req = '0; m_we = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rvalid = 1'b1; #1;
    chk("reset s_req", 32'(s_req), 32'd0);
    chk("reset m_gnt", 32'(m_gnt), 32'd0);
    chk("reset m_rvalid", 32'(m_rvalid), 32'd0);
    s_rvalid = 1'b0;
    reset = 1'b0;

    foreach (vt[i]) apply(vt[i], i);

    // Reset with two transactions outstanding and the pointer moved off 0.
    apply(v(2'b11, 2'b00, 1, 0, 32'h0, ALT,   2'b00, 1, ALTW, 0), 100);
    apply(v(2'b11, 2'b00, 1, 0, 32'h0, 2'b01, 2'b00, 1, 0,    0), 101);
    @(negedge clk);
    reset = 1'b1; m_req = '0; s_gnt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply(v(2'b00, 2'b00, 0, 1, 32'h0000_0031, 2'b00, 2'b00, 0, 0, 0), 102); // late response dropped
    apply(v(2'b11, 2'b00, 1, 0, 32'h0,         2'b01, 2'b00, 1, 0, 0), 103); // r0 wins first

    @(negedge clk);
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
